mac_kbd_link: RTL and testbench

- Macintosh keyboard-cable link between the PS/2 keyboard translator and the VIA shift register (CB1 clock, CB2 data).
- Acts as the keyboard side of the Mac protocol: clocks in 8-bit commands from the Mac and clocks out 8-bit responses.
- Buffers translator response bytes in a FIFO so that no keystroke is lost while a transfer is in flight.

---
 rtl/mac_kbd_link.sv | 238 +++++++++++++++++++++++
 tb/tb_mac_kbd_link.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_kbd_link.sv
// mac_kbd_link: keyboard side of the Macintosh keyboard cable.
// Receives 8-bit commands from the Mac on the VIA CB2 line and clocks out
// 8-bit responses, with a response FIFO fed by the PS/2 translator.
// Optional feature macro: KBD_LINK_NULL_TIMEOUT_EN (null 0x7B response after
// RESP_TIMEOUT ticks in WAIT_RESP with an empty FIFO).
module mac_kbd_link #(
  parameter int unsigned CLK_HALF     = 1300,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned RESP_TIMEOUT = 2000000
) (
  input  logic                          clk32,
  input  logic                          _systemReset,
  input  logic                          clk8_en_p,
  input  logic                          via_cb2_o,
  input  logic                          via_cb2_t,
  input  logic [7:0]                    kbd_in_data,
  input  logic                          kbd_in_strobe,
  output logic                          kbdclk,
  output logic                          kbddata,
  output logic [7:0]                    kbd_out_data,
  output logic                          kbd_out_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned HW = $clog2(CLK_HALF + 1);
  localparam int unsigned BW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    r_state;
  logic [HW-1:0] r_half;
  logic [BW-1:0] r_bit;
  logic          r_kbdclk;
  logic          r_kbddata;
  logic [7:0]    r_shift;
  logic [7:0]    r_out_data;
  logic          r_out_strobe;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic [7:0]    r_mem [FIFO_DEPTH];

  logic [1:0]    w_state_n;
  logic [HW-1:0] w_half_n;
  logic [BW-1:0] w_bit_n;
  logic          w_clk_n;
  logic          w_data_n;
  logic [7:0]    w_shift_n;
  logic [7:0]    w_out_n;
  logic          w_strobe_n;
  logic          w_pop;
  logic [LW-1:0] w_level_n;

  logic w_line;
  logic w_fifo_ne;
  logic w_full;
  logic w_half_hit;
  logic w_push;
  logic w_drop;
  logic w_pop_en;

`ifdef KBD_LINK_NULL_TIMEOUT_EN
  localparam int unsigned TW        = $clog2(RESP_TIMEOUT + 1);
  localparam logic [7:0]  NULL_BYTE = 8'h7B;
  logic [TW-1:0] r_to;
  logic [TW-1:0] w_to_n;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |RESP_TIMEOUT;
`endif

  // Line level and FIFO status decode
  assign w_line     = ~via_cb2_t | via_cb2_o;
  assign w_fifo_ne  = (r_level != '0);
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_half_hit = (r_half == HW'(CLK_HALF));
  assign w_push     = clk8_en_p & kbd_in_strobe & ~w_full;
  assign w_drop     = clk8_en_p & kbd_in_strobe & w_full;
  assign w_pop_en   = clk8_en_p & w_pop;

  // Next-state and output decode for the link FSM
  always_comb begin
    w_state_n  = r_state;
    w_half_n   = r_half;
    w_bit_n    = r_bit;
    w_clk_n    = r_kbdclk;
    w_data_n   = r_kbddata;
    w_shift_n  = r_shift;
    w_out_n    = r_out_data;
    w_strobe_n = 1'b0;
    w_pop      = 1'b0;
`ifdef KBD_LINK_NULL_TIMEOUT_EN
    w_to_n     = r_to;
`endif
    case (r_state)
      S_IDLE: begin
        w_clk_n  = 1'b1;
        w_data_n = 1'b1;
        if (!w_line) begin
          w_state_n = S_CMD;
          w_half_n  = '0;
          w_bit_n   = '0;
        end
      end
      S_CMD: begin
        if (w_half_hit) begin
          w_half_n = '0;
          w_clk_n  = ~r_kbdclk;
          if (!r_kbdclk) begin
            // Rising kbdclk: Mac data is stable, shift it in
            w_shift_n = {r_shift[6:0], w_line};
            w_bit_n   = r_bit + BW'(1);
            if (r_bit == BW'(7)) begin
              w_out_n    = {r_shift[6:0], w_line};
              w_strobe_n = 1'b1;
              w_state_n  = S_WAIT;
`ifdef KBD_LINK_NULL_TIMEOUT_EN
              w_to_n     = '0;
`endif
            end
          end
        end else begin
          w_half_n = r_half + HW'(1);
        end
      end
      S_WAIT: begin
        w_clk_n = 1'b1;
`ifdef KBD_LINK_NULL_TIMEOUT_EN
        if (r_to != TW'(RESP_TIMEOUT)) w_to_n = r_to + TW'(1);
`endif
        if (w_line && w_fifo_ne) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rd];
          w_state_n = S_RESP;
          w_half_n  = '0;
          w_bit_n   = '0;
        end
`ifdef KBD_LINK_NULL_TIMEOUT_EN
        else if (!w_fifo_ne && (r_to == TW'(RESP_TIMEOUT))) begin
          w_shift_n = NULL_BYTE;
          w_state_n = S_RESP;
          w_half_n  = '0;
          w_bit_n   = '0;
        end
`endif
      end
      S_RESP: begin
        if (w_half_hit) begin
          w_half_n = '0;
          if (r_kbdclk) begin
            if (r_bit == BW'(8)) begin
              // Last bit held through its high phase before releasing the line
              w_data_n  = 1'b1;
              w_state_n = S_IDLE;
            end else begin
              w_clk_n   = 1'b0;
              w_data_n  = r_shift[7];
              w_shift_n = {r_shift[6:0], 1'b0};
            end
          end else begin
            w_clk_n = 1'b1;
            w_bit_n = r_bit + BW'(1);
          end
        end else begin
          w_half_n = r_half + HW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // FIFO occupancy after this tick's push/pop
  always_comb begin
    w_level_n = r_level;
    case ({w_push, w_pop_en})
      2'b10:   w_level_n = r_level + LW'(1);
      2'b01:   w_level_n = r_level - LW'(1);
      default: w_level_n = r_level;
    endcase
  end

  // State, datapath and FIFO pointer registers, advanced on clk8_en_p
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      r_state      <= S_IDLE;
      r_half       <= '0;
      r_bit        <= '0;
      r_kbdclk     <= 1'b1;
      r_kbddata    <= 1'b1;
      r_shift      <= '0;
      r_out_data   <= '0;
      r_out_strobe <= 1'b0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
`ifdef KBD_LINK_NULL_TIMEOUT_EN
      r_to         <= '0;
`endif
    end else if (clk8_en_p) begin
      r_state      <= w_state_n;
      r_half       <= w_half_n;
      r_bit        <= w_bit_n;
      r_kbdclk     <= w_clk_n;
      r_kbddata    <= w_data_n;
      r_shift      <= w_shift_n;
      r_out_data   <= w_out_n;
      r_out_strobe <= w_strobe_n;
      r_level      <= w_level_n;
`ifdef KBD_LINK_NULL_TIMEOUT_EN
      r_to         <= w_to_n;
`endif
      if (w_push)   r_wr       <= r_wr + AW'(1);
      if (w_pop_en) r_rd       <= r_rd + AW'(1);
      if (w_drop)   r_overflow <= 1'b1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk32) begin
    if (w_push) r_mem[r_wr] <= kbd_in_data;
  end

  assign kbdclk         = r_kbdclk;
  assign kbddata        = r_kbddata;
  assign kbd_out_data   = r_out_data;
  assign kbd_out_strobe = r_out_strobe;
  assign fifo_level     = r_level;
  assign fifo_overflow  = r_overflow;

endmodule

// File: tb/tb_mac_kbd_link.sv
// tb_mac_kbd_link: directed self-checking bench for mac_kbd_link.
// Acts as the Mac side of the cable; CLK_HALF=4, FIFO_DEPTH=4, RESP_TIMEOUT=50.
module tb_mac_kbd_link;

  localparam int unsigned CLK_HALF     = 4;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned RESP_TIMEOUT = 50;

  logic       clk32 = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cb2_o;
  logic       cb2_t;
  logic [7:0] in_data;
  logic       in_strobe;
  logic       kbdclk;
  logic       kbddata;
  logic [7:0] out_data;
  logic       out_strobe;
  logic [2:0] level;
  logic       overflow;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  alt   = 1'b0;

  mac_kbd_link #(
    .CLK_HALF     (CLK_HALF),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .clk32          (clk32),
    ._systemReset   (rst_n),
    .clk8_en_p      (en),
    .via_cb2_o      (cb2_o),
    .via_cb2_t      (cb2_t),
    .kbd_in_data    (in_data),
    .kbd_in_strobe  (in_strobe),
    .kbdclk         (kbdclk),
    .kbddata        (kbddata),
    .kbd_out_data   (out_data),
    .kbd_out_strobe (out_strobe),
    .fifo_level     (level),
    .fifo_overflow  (overflow)
  );

  always #5 clk32 = ~clk32;

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  // Mac drives the line low, or high either by releasing it or driving a 1
  task automatic set_line(input logic v);
    if (v) begin
      alt   = ~alt;
      cb2_t = alt;
      cb2_o = alt;
    end else begin
      cb2_t = 1'b1;
      cb2_o = 1'b0;
    end
  endtask

  task automatic wait_kbdclk(input logic lvl, input string tag);
    int n;
    n = 0;
    while (kbdclk !== lvl && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (kbdclk !== lvl) begin
      n_err++;
      $display("FAIL %s kbdclk wait: got %b want %b", tag, kbdclk, lvl);
    end
  endtask

  task automatic push(input logic [7:0] b);
    in_data   = b;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
  endtask

  // Mac sends a command; ends on the sample of the 8th rising kbdclk
  task automatic send_cmd(input logic [7:0] b, input string tag);
    set_line(1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_kbdclk(1'b0, tag);
      set_line(b[7-i]);
      wait_kbdclk(1'b1, tag);
      n_cmp++;
      if (out_strobe !== (i == 7)) begin
        n_err++;
        $display("FAIL %s strobe at rise %0d: got %b want %b", tag, i + 1, out_strobe, (i == 7));
      end
    end
  endtask

  // Mac releases the line and samples the response on rising kbdclk
  task automatic recv(output logic [7:0] r, input string tag);
    r = '0;
    set_line(1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_kbdclk(1'b0, tag);
      wait_kbdclk(1'b1, tag);
      r[7-i] = kbddata;
    end
    repeat (CLK_HALF + 2) tick();
    n_cmp++;
    if (kbddata !== 1'b1 || kbdclk !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle after resp: got clk=%b data=%b want 1 1", tag, kbdclk, kbddata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; cb2_t = 1'b0; cb2_o = 1'b0;
    in_data = 8'h00; in_strobe = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({kbdclk, kbddata, out_data, out_strobe, level, overflow} !== {1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got clk=%b data=%b out=%h stb=%b lvl=%0d ovf=%b want 1 1 00 0 0 0",
               kbdclk, kbddata, out_data, out_strobe, level, overflow);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_cmd();
    int drops;
    send_cmd(8'h10, "cmd10");
    n_cmp++;
    if (out_data !== 8'h10) begin
      n_err++;
      $display("FAIL cmd10 data: got %h want 10", out_data);
    end
    tick();
    n_cmp++;
    if (out_strobe !== 1'b0) begin
      n_err++;
      $display("FAIL cmd10 strobe width: got %b want 0", out_strobe);
    end
    // Line still low from the last bit and FIFO empty: must stay waiting
    drops = 0;
    repeat (20) begin
      tick();
      if (kbdclk !== 1'b1) drops++;
    end
    n_cmp++;
    if (drops != 0) begin
      n_err++;
      $display("FAIL wait low-line: got %0d kbdclk low ticks want 0", drops);
    end
  endtask

  task automatic test_response();
    logic [7:0] r;
    push(8'h31);
    repeat (3) tick();
    n_cmp++;
    if (level !== 3'd1 || kbdclk !== 1'b1) begin
      n_err++;
      $display("FAIL resp31 pending: got lvl=%0d clk=%b want 1 1", level, kbdclk);
    end
    recv(r, "resp31");
    n_cmp++;
    if (r !== 8'h31) begin
      n_err++;
      $display("FAIL resp31 byte: got %h want 31", r);
    end
    n_cmp++;
    if (level !== 3'd0 || out_data !== 8'h10) begin
      n_err++;
      $display("FAIL resp31 after: got lvl=%0d out=%h want 0 10", level, out_data);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] r;
    for (int k = 1; k <= 5; k++) push(8'(k));
    n_cmp++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: got lvl=%0d ovf=%b want 4 1", level, overflow);
    end
    for (int k = 1; k <= 3; k++) begin
      send_cmd(8'(8'h20 + k), "ovf_cmd");
      recv(r, "ovf_resp");
      n_cmp++;
      if (r !== 8'(k)) begin
        n_err++;
        $display("FAIL ovf resp %0d: got %h want %h", k, r, 8'(k));
      end
    end
    n_cmp++;
    if (level !== 3'd1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf drain: got lvl=%0d ovf=%b want 1 1", level, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h04; exp_q[1] = 8'h06; exp_q[2] = 8'h07;
    push(8'h06);
    send_cmd(8'h00, "b2b_cmd");
    // Push lands in the same tick that RESP pops the head
    set_line(1'b1);
    in_data   = 8'h07;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    n_cmp++;
    if (level !== 3'd2) begin
      n_err++;
      $display("FAIL push+pop level: got %0d want 2", level);
    end
    for (int k = 0; k < 3; k++) begin
      if (k != 0) send_cmd(8'h5C, "b2b_cmd");
      recv(r, "b2b_resp");
      n_cmp++;
      if (r !== exp_q[k]) begin
        n_err++;
        $display("FAIL wrap order %0d: got %h want %h", k, r, exp_q[k]);
      end
    end
    n_cmp++;
    if (level !== 3'd0) begin
      n_err++;
      $display("FAIL b2b drain: got %0d want 0", level);
    end
  endtask

  task automatic test_push_empty();
    logic [7:0] r;
    send_cmd(8'hFF, "pe_cmd");
    repeat (10) tick();
    push(8'h55);
    n_cmp++;
    if (level !== 3'd1 || kbdclk !== 1'b1) begin
      n_err++;
      $display("FAIL push-empty same tick: got lvl=%0d clk=%b want 1 1", level, kbdclk);
    end
    tick();
    n_cmp++;
    if (level !== 3'd0) begin
      n_err++;
      $display("FAIL push-empty next tick pop: got %0d want 0", level);
    end
    recv(r, "pe_resp");
    n_cmp++;
    if (r !== 8'h55) begin
      n_err++;
      $display("FAIL push-empty byte: got %h want 55", r);
    end
  endtask

`ifdef KBD_LINK_NULL_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] r;
    int cnt;
    send_cmd(8'h10, "to_cmd");
    set_line(1'b1);
    cnt = 0;
    while (kbdclk === 1'b1 && cnt < 300) begin
      tick();
      cnt++;
    end
    n_cmp++;
    if (cnt != RESP_TIMEOUT + CLK_HALF + 2) begin
      n_err++;
      $display("FAIL timeout first fall: got %0d ticks want %0d", cnt, RESP_TIMEOUT + CLK_HALF + 2);
    end
    recv(r, "to_resp");
    n_cmp++;
    if (r !== 8'h7B || level !== 3'd0) begin
      n_err++;
      $display("FAIL timeout byte: got %h lvl=%0d want 7b 0", r, level);
    end
  endtask
`else
  task automatic test_timeout();
    logic [7:0] r;
    int drops;
    send_cmd(8'h10, "nto_cmd");
    set_line(1'b1);
    drops = 0;
    repeat (1000) begin
      tick();
      if (kbdclk !== 1'b1) drops++;
    end
    n_cmp++;
    if (drops != 0) begin
      n_err++;
      $display("FAIL no-timeout idle: got %0d low ticks want 0", drops);
    end
    push(8'h5A);
    recv(r, "nto_resp");
    n_cmp++;
    if (r !== 8'h5A) begin
      n_err++;
      $display("FAIL no-timeout byte: got %h want 5a", r);
    end
  endtask
`endif

  task automatic test_enable();
    en = 1'b0;
    in_data = 8'hEE;
    in_strobe = 1'b1;
    set_line(1'b0);
    repeat (12) tick();
    in_strobe = 1'b0;
    n_cmp++;
    if (level !== 3'd0 || kbdclk !== 1'b1) begin
      n_err++;
      $display("FAIL enable gated: got lvl=%0d clk=%b want 0 1", level, kbdclk);
    end
    set_line(1'b1);
    en = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if (level !== 3'd0 || kbdclk !== 1'b1) begin
      n_err++;
      $display("FAIL enable resume: got lvl=%0d clk=%b want 0 1", level, kbdclk);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int drops;
    push(8'h77);
    set_line(1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_kbdclk(1'b0, "rm_cmd");
      set_line(i[0]);
      wait_kbdclk(1'b1, "rm_cmd");
    end
    wait_kbdclk(1'b0, "rm_cmd");
    @(posedge clk32);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({kbdclk, kbddata, level, overflow, out_strobe} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async reset: got clk=%b data=%b lvl=%0d ovf=%b stb=%b want 1 1 0 0 0",
               kbdclk, kbddata, level, overflow, out_strobe);
    end
    set_line(1'b1);
    tick();
    rst_n = 1'b1;
    drops = 0;
    repeat (20) begin
      tick();
      if (kbdclk !== 1'b1) drops++;
    end
    n_cmp++;
    if (drops != 0 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL post-reset idle: got drops=%0d out=%h want 0 00", drops, out_data);
    end
    send_cmd(8'hA5, "rm_cmdA5");
    n_cmp++;
    if (out_data !== 8'hA5) begin
      n_err++;
      $display("FAIL post-reset cmd: got %h want a5", out_data);
    end
    push(8'h11);
    recv(r, "rm_resp");
    n_cmp++;
    if (r !== 8'h11) begin
      n_err++;
      $display("FAIL post-reset resp: got %h want 11", r);
    end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_response();
    test_overflow();
    test_back_to_back();
    test_push_empty();
    test_timeout();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
